// File: rtl/latch_write_sequencer.sv
// latch_write_sequencer
// Drives a bank of W gated-D latches through a registered setup -> gate -> hold
// sequence after accepting a word on a valid/ready handshake. Every output is
// a flop output, so the latch gate line never glitches.
// Optional feature macro: LATCH_READBACK_EN
//   defined   : adds the CHECK state, a 2-flop lat_Q synchronizer, the stored-word
//               compare and a saturating mismatch counter.
//   undefined : done follows HOLD directly, match reads 1 after the first
//               completed write and err_cnt is constant 0.
module latch_write_sequencer #(
    parameter int W         = 4,
    parameter int SETUP_CYC = 2,
    parameter int GATE_CYC  = 4,
    parameter int HOLD_CYC  = 2
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         req_valid,
    input  logic [W-1:0] req_data,
    output logic         req_ready,
    output logic [W-1:0] lat_D,
    output logic         lat_G,
    input  logic [W-1:0] lat_Q,
    output logic         done,
    output logic         match,
    output logic [7:0]   err_cnt
);

    // Phase counters hold "cycles remaining minus one"; the phase ends when it reads 0.
    localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
    localparam logic [7:0] GATE_LD  = 8'(GATE_CYC - 1);
    localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);

`ifdef LATCH_READBACK_EN
    // CHECK spans two cycles so the synchronizer sees lat_Q only after the gate is low.
    localparam logic [7:0] CHECK_LD = 8'd1;

    typedef enum logic [2:0] {IDLE, SETUP, GATE, HOLD, CHECK} state_t;
`else
    typedef enum logic [1:0] {IDLE, SETUP, GATE, HOLD} state_t;
`endif

    state_t       state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [W-1:0] data_q, data_d;
    logic         gate_q, gate_d;
    logic         ready_q, ready_d;
    logic         done_q, done_d;
    logic         match_q, match_d;

`ifdef LATCH_READBACK_EN
    logic [W-1:0] sync1_q, sync2_q;
    logic [7:0]   err_q, err_d;

    // Saturating increment for the mismatch counter.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction
`else
    // The latch outputs have no consumer without readback.
    logic unused_lat_q;
    assign unused_lat_q = ^lat_Q;
`endif

    // Next-state, phase counter and output-register decode for the write sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        gate_d  = gate_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        match_d = match_q;
`ifdef LATCH_READBACK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    data_d  = req_data;
                    ready_d = 1'b0;
                    cnt_d   = SETUP_LD;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == 8'd0) begin
                    gate_d  = 1'b1;
                    cnt_d   = GATE_LD;
                    state_d = GATE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            GATE: begin
                if (cnt_q == 8'd0) begin
                    gate_d  = 1'b0;
                    cnt_d   = HOLD_LD;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            HOLD: begin
                if (cnt_q == 8'd0) begin
`ifdef LATCH_READBACK_EN
                    cnt_d   = CHECK_LD;
                    state_d = CHECK;
`else
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    match_d = 1'b1;
                    state_d = IDLE;
`endif
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
`ifdef LATCH_READBACK_EN
            CHECK: begin
                if (cnt_q == 8'd0) begin
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    match_d = (sync2_q == data_q);
                    if (sync2_q != data_q) begin
                        err_d = sat_inc(err_q);
                    end
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state and output registers; reset aborts any sequence in flight.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            data_q  <= '0;
            gate_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            gate_q  <= gate_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            match_q <= match_d;
        end
    end

`ifdef LATCH_READBACK_EN
    // Two-flop synchronizer for the asynchronous latch outputs plus the mismatch counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            err_q   <= 8'd0;
        end else begin
            sync1_q <= lat_Q;
            sync2_q <= sync1_q;
            err_q   <= err_d;
        end
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = 8'd0;
`endif

    assign req_ready = ready_q;
    assign lat_D     = data_q;
    assign lat_G     = gate_q;
    assign done      = done_q;
    assign match     = match_q;

endmodule

// File: tb/tb_latch_write_sequencer.sv
// Testbench for latch_write_sequencer: a default-parameter instance and a
// SETUP=GATE=HOLD=1 instance, each driving a behavioural latch bank with an
// optional stuck-bit mask. Expected completions are queued on accept and
// popped when the DUT pulses done; an edge-indexed model predicts every output.
module tb_latch_write_sequencer;

`ifdef LATCH_READBACK_EN
    localparam bit RB   = 1'b1;
    localparam int DL0  = 10;
    localparam int DL1  = 5;
    localparam int GAP0 = 11;
`else
    localparam bit RB   = 1'b0;
    localparam int DL0  = 8;
    localparam int DL1  = 3;
    localparam int GAP0 = 9;
`endif

    typedef struct {
        logic [3:0] d;
        logic       m;
        logic [7:0] e;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       rv0, rr0, lg0, dn0, mt0;
    logic [3:0] rd0, ld0, lq0;
    logic [7:0] ec0;
    logic       rv1, rr1, lg1, dn1, mt1;
    logic [3:0] rd1, ld1, lq1;
    logic [7:0] ec1;
    logic [3:0] mask0, mask1;
    logic [3:0] lat0_mem, lat1_mem;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    int   edge_n = 0;
    int   ps[2] = '{2, 1};
    int   pg[2] = '{4, 1};
    int   pl[2] = '{DL0, DL1};
    logic m_seq[2] = '{1'b0, 1'b0};
    int   m_acc[2] = '{0, 0};
    logic [3:0] m_d[2] = '{4'h0, 4'h0};
    logic m_match[2] = '{1'b0, 1'b0};
    int   m_err[2] = '{0, 0};
    logic m_pm[2] = '{1'b0, 1'b0};
    int   m_pe[2] = '{0, 0};
    logic dut_acc[2] = '{1'b0, 1'b0};
    logic seen_done[2] = '{1'b0, 1'b0};
    exp_t q0[$];
    exp_t q1[$];
    bit   btb = 1'b0;
    int   last_acc0 = -1;
    int   btb_n = 0;

    latch_write_sequencer #(.W(4), .SETUP_CYC(2), .GATE_CYC(4), .HOLD_CYC(2)) dut (
        .Clk(clk), .Reset(reset), .req_valid(rv0), .req_data(rd0), .req_ready(rr0),
        .lat_D(ld0), .lat_G(lg0), .lat_Q(lq0), .done(dn0), .match(mt0), .err_cnt(ec0)
    );

    latch_write_sequencer #(.W(4), .SETUP_CYC(1), .GATE_CYC(1), .HOLD_CYC(1)) dut_c (
        .Clk(clk), .Reset(reset), .req_valid(rv1), .req_data(rd1), .req_ready(rr1),
        .lat_D(ld1), .lat_G(lg1), .lat_Q(lq1), .done(dn1), .match(mt1), .err_cnt(ec1)
    );

    // Behavioural gated-D latches, transparent while the gate is high.
    always_latch begin
        if (lg0) lat0_mem <= ld0;
    end
    always_latch begin
        if (lg1) lat1_mem <= ld1;
    end
    assign lq0 = lat0_mem & mask0;
    assign lq1 = lat1_mem & mask1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
        end
    endtask

    function automatic int sat255(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // One clock: advance the model on the edge, then compare every output 1 time unit later.
    task automatic tick();
        logic pre_rst, exp_done, mis, g, dn, mt, r, exp_g;
        logic pv[2];
        logic [3:0] pd[2];
        logic pa[2];
        logic [3:0] d, mk;
        logic [7:0] ec;
        int rel, qs;
        string sx;
        exp_t e;
        pre_rst = reset;
        pv[0] = rv0; pv[1] = rv1;
        pd[0] = rd0; pd[1] = rd1;
        pa[0] = rv0 && rr0 && !reset;
        pa[1] = rv1 && rr1 && !reset;
        @(posedge clk);
        #1;
        edge_n++;
        for (int i = 0; i < 2; i++) begin
            sx = (i == 0) ? "0" : "1";
            mk = (i == 0) ? mask0 : mask1;
            exp_done = 1'b0;
            dut_acc[i] = pa[i];
            if (pre_rst) begin
                m_seq[i] = 1'b0; m_d[i] = 4'h0; m_err[i] = 0; m_match[i] = 1'b0;
                if (i == 0) begin q0.delete(); last_acc0 = -1; end
                else q1.delete();
            end else if (!m_seq[i] && pv[i]) begin
                m_seq[i] = 1'b1;
                m_acc[i] = edge_n;
                m_d[i]   = pd[i];
                mis      = RB && ((pd[i] & mk) != pd[i]);
                m_pm[i]  = !mis;
                m_pe[i]  = sat255(m_err[i] + int'(mis));
                e.d = pd[i]; e.m = !mis; e.e = 8'(m_pe[i]);
                if (i == 0) q0.push_back(e); else q1.push_back(e);
            end else if (m_seq[i] && (edge_n - m_acc[i] == pl[i])) begin
                m_seq[i]   = 1'b0;
                exp_done   = 1'b1;
                m_match[i] = m_pm[i];
                m_err[i]   = m_pe[i];
            end
            rel = edge_n - m_acc[i];
            exp_g = m_seq[i] && (rel >= ps[i]) && (rel < ps[i] + pg[i]);
            if (i == 0) begin g = lg0; d = ld0; r = rr0; dn = dn0; mt = mt0; ec = ec0; end
            else        begin g = lg1; d = ld1; r = rr1; dn = dn1; mt = mt1; ec = ec1; end
            check({"lat_g", sx}, g, exp_g);
            check({"lat_d", sx}, d, m_d[i]);
            check({"ready", sx}, r, !m_seq[i]);
            check({"done", sx}, dn, exp_done);
            check({"match", sx}, mt, m_match[i]);
            check({"err_cnt", sx}, ec, m_err[i]);
            if (dn) begin
                seen_done[i] = 1'b1;
                check({"done_edge", sx}, edge_n - m_acc[i], pl[i]);
                qs = (i == 0) ? q0.size() : q1.size();
                check({"sb_nonempty", sx}, (qs != 0), 1);
                if (qs != 0) begin
                    e = (i == 0) ? q0.pop_front() : q1.pop_front();
                    check({"sb_data", sx}, d, e.d);
                    check({"sb_match", sx}, mt, e.m);
                    check({"sb_err", sx}, ec, e.e);
                end
            end
        end
        if (pa[0] && !pre_rst) begin
            if (btb) begin
                btb_n++;
                if (last_acc0 >= 0) check("acc_gap", edge_n - last_acc0, GAP0);
            end
            last_acc0 = edge_n;
        end
    endtask

    task automatic write(input int i, input logic [3:0] dat);
        int n;
        logic ok;
        n = 0;
        ok = 1'b0;
        seen_done[i] = 1'b0;
        if (i == 0) begin rv0 = 1'b1; rd0 = dat; end
        else        begin rv1 = 1'b1; rd1 = dat; end
        while (!ok && n < 40) begin
            tick();
            n++;
            ok = dut_acc[i];
        end
        if (i == 0) rv0 = 1'b0; else rv1 = 1'b0;
        check("wr_accept", ok, 1);
    endtask

    task automatic wait_done(input int i);
        int n;
        n = 0;
        while (!seen_done[i] && n < 40) begin
            tick();
            n++;
        end
        check("done_seen", seen_done[i], 1);
    endtask

    initial begin
        int k;
        reset = 1'b1;
        rv0 = 1'b0; rd0 = 4'h0; rv1 = 1'b0; rd1 = 4'h0;
        mask0 = 4'hF; mask1 = 4'hF;
        tick();
        tick();
        check("rst_ready", rr0, 1);
        check("rst_lat_g", lg0, 0);
        check("rst_lat_d", ld0, 0);
        check("rst_match", mt0, 0);
        reset = 1'b0;
        tick();

        // Single write with a healthy latch.
        write(0, 4'hA);
        wait_done(0);
        check("t1_match", mt0, 1);
        check("t1_err", ec0, 0);

        // Stuck-at-0 bit 0, then saturate the mismatch counter.
        mask0 = 4'hE;
        write(0, 4'hF);
        wait_done(0);
        check("stuck_match", mt0, !RB);
        check("stuck_err", ec0, RB ? 1 : 0);
        repeat (300) begin
            write(0, 4'hF);
            wait_done(0);
        end
        check("err_sat", ec0, RB ? 255 : 0);
        mask0 = 4'hF;

        // Requests pulsed mid-sequence must be ignored.
        write(0, 4'h3);
        for (int n = 1; n <= 7; n++) begin
            rv0 = n[0];
            rd0 = 4'($urandom);
            tick();
        end
        rv0 = 1'b0;
        wait_done(0);
        check("pulse_lat_d", ld0, 4'h3);

        // Back-to-back words with req_valid held high.
        btb = 1'b1; last_acc0 = -1; btb_n = 0; k = 1;
        rv0 = 1'b1; rd0 = 4'h1;
        for (int n = 0; n < 60 && k <= 3; n++) begin
            tick();
            if (dut_acc[0]) k++;
            if (k > 3) rv0 = 1'b0;
            else if (m_seq[0]) rd0 = 4'($urandom);
            else rd0 = 4'(k);
        end
        rv0 = 1'b0;
        seen_done[0] = 1'b0;
        wait_done(0);
        btb = 1'b0;
        check("btb_accepts", btb_n, 3);
        check("btb_last", ld0, 4'h3);

        // Reset while the gate is high (edge 3 after accept).
        write(0, 4'h6);
        tick();
        tick();
        check("pre_rst_g", lg0, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_g", lg0, 0);
        check("mid_rst_d", ld0, 0);
        check("mid_rst_ready", rr0, 1);
        check("mid_rst_err", ec0, 0);
        seen_done[0] = 1'b0;
        repeat (15) tick();
        check("mid_rst_no_done", seen_done[0], 0);

        // Minimum phase lengths.
        write(1, 4'h9);
        wait_done(1);
        check("corner_match", mt1, 1);
        check("corner_d", ld1, 4'h9);

        // Latch outputs tied low.
        mask0 = 4'h0;
        write(0, 4'h5);
        wait_done(0);
        check("tied_match", mt0, !RB);
        check("tied_err", ec0, RB ? 1 : 0);
        mask0 = 4'hF;

        repeat (3) tick();
        check("sb_left0", q0.size(), 0);
        check("sb_left1", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
